// File: rtl/board_move_ctrl.sv
// 2048 move sequencer: slides/merges one 4-cell line per cycle, spawns a 2-tile
// if the board changed, then evaluates win/game-over and pulses o_done.
module board_move_ctrl #(
    parameter int TILE_W    = 12,
    parameter int WIN_VALUE = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [1:0]            i_dir,
    input  logic [3:0]            i_seed,
    input  logic [16*TILE_W-1:0]  i_board_in,
    output logic [16*TILE_W-1:0]  o_board_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_moved,
    output logic                  o_win,
    output logic                  o_over,
    output logic [15:0]           o_score_inc
);
    typedef enum logic [2:0] {S_IDLE, S_SLIDE, S_SPAWN, S_EVAL, S_DONE} state_t;

    localparam logic [TILE_W-1:0] WIN_T = TILE_W'(WIN_VALUE);

    state_t                r_state, w_state_next;
    logic [16*TILE_W-1:0]  r_board;
    logic [1:0]            r_dir, r_line;
    logic [3:0]            r_seed, r_idx;
    logic                  r_moved, r_win, r_over;
    logic [15:0]           r_score;

    logic [TILE_W-1:0]     w_cell [16];
    logic [3:0]            w_lidx [4];
    logic [TILE_W-1:0]     w_lin  [4];
    logic [TILE_W-1:0]     w_lout [4];
    logic [TILE_W+1:0]     w_lsum;
    logic                  w_line_moved;
    logic [16:0]           w_score_sum;
    logic [15:0]           w_score_next;
    logic                  w_spawn_hit, w_any_win, w_full, w_pair;

    // Position 0 is the front of the line, i.e. the edge tiles slide toward.
    function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] line,
                                            input logic [1:0] pos);
        case (dir)
            2'b00:   return {pos, line};
            2'b01:   return {~pos, line};
            2'b10:   return {line, pos};
            default: return {line, ~pos};
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cell
            assign w_cell[gi] = r_board[TILE_W*gi +: TILE_W];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_line
            assign w_lidx[gi] = cell_idx(r_dir, r_line, 2'(gi));
            assign w_lin[gi]  = w_cell[w_lidx[gi]];
        end
    endgenerate

    // Compact toward the front, then merge front-first; a merged tile is skipped.
    always_comb begin
        logic [TILE_W-1:0] c [4];
        logic [3:0]        eq;
        logic [1:0]        n, j;
        logic              skip;
        for (int p = 0; p < 4; p++) begin
            c[p]      = '0;
            w_lout[p] = '0;
        end
        n            = '0;
        j            = '0;
        skip         = 1'b0;
        w_lsum       = '0;
        w_line_moved = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (w_lin[p] != '0) begin
                c[n] = w_lin[p];
                n    = n + 2'd1;
            end
        end
        eq[0] = (c[0] == c[1]);
        eq[1] = (c[1] == c[2]);
        eq[2] = (c[2] == c[3]);
        eq[3] = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[p] != '0) begin
                if (eq[p]) begin
                    w_lout[j] = {c[p][TILE_W-2:0], 1'b0};
                    w_lsum    = w_lsum + {1'b0, c[p], 1'b0};
                    skip      = 1'b1;
                end else begin
                    w_lout[j] = c[p];
                end
                j = j + 2'd1;
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (w_lout[p] != w_lin[p]) w_line_moved = 1'b1;
        end
    end

    assign w_score_sum  = {1'b0, r_score} + 17'(w_lsum);
    assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    assign w_spawn_hit  = (w_cell[r_idx] == '0);

    always_comb begin
        w_any_win = 1'b0;
        w_full    = 1'b1;
        w_pair    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (w_cell[k] == WIN_T) w_any_win = 1'b1;
            if (w_cell[k] == '0)    w_full    = 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (w_cell[4*r+c] == w_cell[4*r+c+1]) w_pair = 1'b1;
                if (w_cell[4*c+r] == w_cell[4*c+r+4]) w_pair = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_SLIDE;
            S_SLIDE: if (r_line == 2'd3)
                         w_state_next = (r_moved || w_line_moved) ? S_SPAWN : S_EVAL;
            S_SPAWN: if (w_spawn_hit) w_state_next = S_EVAL;
            S_EVAL:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_board <= '0;
            r_dir   <= '0;
            r_seed  <= '0;
            r_line  <= '0;
            r_idx   <= '0;
            r_moved <= 1'b0;
            r_win   <= 1'b0;
            r_over  <= 1'b0;
            r_score <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_board <= i_board_in;
                    r_dir   <= i_dir;
                    r_seed  <= i_seed;
                    r_line  <= '0;
                    r_moved <= 1'b0;
                    r_win   <= 1'b0;
                    r_over  <= 1'b0;
                    r_score <= '0;
                end
                S_SLIDE: begin
                    for (int p = 0; p < 4; p++)
                        r_board[TILE_W*w_lidx[p] +: TILE_W] <= w_lout[p];
                    r_line  <= r_line + 2'd1;
                    r_moved <= r_moved | w_line_moved;
                    r_score <= w_score_next;
                    r_idx   <= r_seed;
                end
                S_SPAWN: begin
                    if (w_spawn_hit) r_board[TILE_W*r_idx +: TILE_W] <= TILE_W'(2);
                    else             r_idx <= r_idx + 4'd1;
                end
                S_EVAL: begin
                    r_win  <= w_any_win;
                    r_over <= w_full && !w_pair;
                end
                default: ;
            endcase
        end
    end

    assign o_board_out = r_board;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_moved     = r_moved;
    assign o_win       = r_win;
    assign o_over      = r_over;
    assign o_score_inc = r_score;
endmodule

// File: tb/tb_board_move_ctrl.sv
// Table-driven scoreboard bench for board_move_ctrl: one line per move transaction.
module tb_board_move_ctrl;
    localparam int TW = 12;
    localparam int BW = 16 * TW;

    typedef int cells_t [16];
    typedef struct {
        int             id;
        logic [BW-1:0]  bin;
        logic [1:0]     dir;
        logic [3:0]     seed;
        logic [BW-1:0]  bexp;
        logic [15:0]    score;
        logic           moved;
        logic           win;
        logic           over;
        int             lat;
    } vec_t;

    logic           clk = 1'b0;
    logic           i_rst_n = 1'b1;
    logic           i_start = 1'b0;
    logic [1:0]     i_dir = '0;
    logic [3:0]     i_seed = '0;
    logic [BW-1:0]  i_board_in = '0;
    logic [BW-1:0]  o_board_out;
    logic           o_busy, o_done, o_moved, o_win, o_over;
    logic [15:0]    o_score_inc;

    int     checks = 0;
    int     failures = 0;
    vec_t   vecs [10];
    int     nv = 0;
    vec_t   exp_q [$];
    cells_t ca, cb;

    board_move_ctrl #(.TILE_W(TW), .WIN_VALUE(256)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_dir       (i_dir),
        .i_seed      (i_seed),
        .i_board_in  (i_board_in),
        .o_board_out (o_board_out),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_moved     (o_moved),
        .o_win       (o_win),
        .o_over      (o_over),
        .o_score_inc (o_score_inc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] pk(input cells_t c);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[TW*i +: TW] = TW'(c[i]);
        return b;
    endfunction

    task automatic clr();
        for (int i = 0; i < 16; i++) begin
            ca[i] = 0;
            cb[i] = 0;
        end
    endtask

    task automatic add(input int dir, input int seed, input int score, input bit moved,
                       input bit win, input bit over, input int lat);
        vecs[nv] = '{nv, pk(ca), 2'(dir), 4'(seed), pk(cb), 16'(score), moved, win, over, lat};
        nv++;
    endtask

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int pa, input int pb);
        vec_t e;
        int   done_cyc;
        @(posedge clk); #1;
        i_board_in = v.bin;
        i_dir      = v.dir;
        i_seed     = v.seed;
        i_start    = 1'b1;
        exp_q.push_back(v);
        @(posedge clk); #1;
        i_start    = 1'b0;
        i_board_in = ~v.bin;
        check("busy_cycle1", BW'(o_busy), BW'(1));
        done_cyc = -1;
        for (int c = 1; c < 40; c++) begin
            i_start = (c == pa) || (c == pb);
            if (o_done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        e = exp_q.pop_front();
        check("done_cycle", BW'(done_cyc), BW'(e.lat));
        check("board", o_board_out, e.bexp);
        check("score_inc", BW'(o_score_inc), BW'(e.score));
        check("moved", BW'(o_moved), BW'(e.moved));
        check("win", BW'(o_win), BW'(e.win));
        check("over", BW'(o_over), BW'(e.over));
        $display("vec %0d dir=%0d seed=%0d done_cycle=%0d score=%0d moved=%0b win=%0b over=%0b",
                 e.id, e.dir, e.seed, done_cyc, o_score_inc, o_moved, o_win, o_over);
        @(posedge clk); #1;
        i_start = 1'b0;
        check("done_pulse_end", BW'(o_done), BW'(0));
        check("idle_after_done", BW'(o_busy), BW'(0));
        check("board_hold", o_board_out, e.bexp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_board"}, o_board_out, '0);
        check({tag, "_busy"}, BW'(o_busy), BW'(0));
        check({tag, "_done"}, BW'(o_done), BW'(0));
        check({tag, "_moved"}, BW'(o_moved), BW'(0));
        check({tag, "_win"}, BW'(o_win), BW'(0));
        check({tag, "_over"}, BW'(o_over), BW'(0));
        check({tag, "_score"}, BW'(o_score_inc), BW'(0));
    endtask

    initial begin
        bit saw_done;

        // 0: left, [2,2,2,2] -> [4,4,0,0], spawn at cell 2
        clr(); ca[0] = 2; ca[1] = 2; ca[2] = 2; ca[3] = 2;
        cb[0] = 4; cb[1] = 4; cb[2] = 2;
        add(2, 0, 8, 1, 0, 0, 9);
        // 1: right, row1 [2,0,2,4] -> cells 6,7 = 4,4, spawn at cell 0
        clr(); ca[4] = 2; ca[6] = 2; ca[7] = 4;
        cb[0] = 2; cb[6] = 4; cb[7] = 4;
        add(3, 0, 4, 1, 0, 0, 7);
        // 2: up, column already packed, nothing moves
        clr(); ca[0] = 2; ca[4] = 4; ca[8] = 8; ca[12] = 16;
        cb = ca;
        add(0, 3, 0, 0, 0, 0, 6);
        // 3: left, 128+128 -> 256 wins, spawn at seed 5
        clr(); ca[0] = 128; ca[1] = 128;
        cb[0] = 256; cb[5] = 2;
        add(2, 5, 256, 1, 1, 0, 7);
        // 4: checkerboard, stuck board
        clr();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ca[4*r+c] = ((r + c) % 2 == 0) ? 2 : 4;
        cb = ca;
        add(2, 0, 0, 0, 0, 1, 6);
        // 5: left, [4,4,8,0] -> [8,8,0,0]: merged tile does not re-merge
        clr(); ca[0] = 4; ca[1] = 4; ca[2] = 8;
        cb[0] = 8; cb[1] = 8; cb[2] = 2;
        add(2, 0, 8, 1, 0, 0, 9);
        // 6: down, column 1 [2,2,4,0] -> cells 9,13 = 4,4, spawn skips cell 13
        clr(); ca[1] = 2; ca[5] = 2; ca[9] = 4;
        cb[9] = 4; cb[13] = 4; cb[14] = 2;
        add(1, 13, 4, 1, 0, 0, 8);
        // 7: right, spawn index wraps from 15 to 0
        clr(); ca[12] = 2;
        cb[15] = 2; cb[0] = 2;
        add(3, 15, 0, 1, 0, 0, 8);
        // 8: left, 2048+2048 truncates to 0 in 12 bits, spawn lands on cell 0
        clr(); ca[0] = 2048; ca[1] = 2048;
        cb[0] = 2;
        add(2, 0, 4096, 1, 0, 0, 7);

        #2 i_rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        i_rst_n = 1'b1;

        for (int k = 0; k < nv; k++) begin
            if (k == 2) run_vec(vecs[k], 2, 6);
            else        run_vec(vecs[k], -1, -1);
        end

        // Reset asserted in cycle 3 of a moving case.
        @(posedge clk); #1;
        i_board_in = vecs[0].bin;
        i_dir      = vecs[0].dir;
        i_seed     = vecs[0].seed;
        i_start    = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (o_done) saw_done = 1'b1;
            if (c == 3) i_rst_n = 1'b1;
        end
        check("no_done_after_reset", BW'(saw_done), BW'(0));
        run_vec(vecs[0], -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
